// File: rtl/alu_op_sequencer.sv
// Sequences multi-pass ALU operations for the 6502 core: request in, ALU drive/capture, result+flags out.
// Optional BCD fixup passes for ADC/SBC are compiled in with `define ALU_SEQ_DECIMAL_EN.
module alu_op_sequencer #(
  parameter int              DW       = 8,
  parameter int              FW       = 4,
  parameter logic [FW-1:0]   NOP_FUNC = 4'hF
) (
  input  logic          phi1,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic          req_carry,
  input  logic          req_dec,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [FW-1:0] alu_func,
  output logic          alu_carry_in,
  input  logic [DW-1:0] alu_dout,
  input  logic          alu_wout,
  input  logic          alu_carry_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [3:0]    rsp_flags,
  output logic [3:0]    rsp_fmask,
  output logic          rsp_wb,
  output logic          rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_ADC = 3'd0;
  localparam logic [2:0] OP_SBC = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORA = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;
  localparam logic [2:0] OP_ASL = 3'd6;
  localparam logic [2:0] OP_ROL = 3'd7;

  // ALU function encodings; must track the core's `SUM/`AND/`OR/`XOR/`SR defines.
  localparam logic [FW-1:0] FN_SUM = FW'(0);
  localparam logic [FW-1:0] FN_AND = FW'(1);
  localparam logic [FW-1:0] FN_OR  = FW'(2);
  localparam logic [FW-1:0] FN_XOR = FW'(3);
  localparam logic [FW-1:0] FN_SR  = FW'(4);

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] bs_q, bs_d;
  logic          cin_q, cin_d;
  logic          dec_q, dec_d;
  logic [1:0]    pass_q, pass_d;
  logic [DW-1:0] r_q, r_d;
  logic          c_q, c_d;
  logic          err_q, err_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [FW-1:0] alu_func_q, alu_func_d;
  logic          alu_cin_q, alu_cin_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]    rsp_flags_q, rsp_flags_d;
  logic [3:0]    rsp_fmask_q, rsp_fmask_d;
  logic          rsp_wb_q, rsp_wb_d;
  logic          rsp_err_q, rsp_err_d;

  logic          c_now;
  logic [DW-1:0] v_vec;
  logic [3:0]    fmask;
  logic          flag_c;

`ifdef ALU_SEQ_DECIMAL_EN
  logic          dec_adc;
  logic          dec_go;
  logic [DW-1:0] hc_vec;
  logic          lo_fix;
  logic          hi_fix;

  assign dec_adc = (op_q == OP_ADC);
  assign dec_go  = dec_q && (op_q == OP_ADC || op_q == OP_SBC) && (pass_q != 2'd2);
  assign hc_vec  = a_q ^ bs_q ^ alu_dout;
  // ADC carries accumulate across fixups; SBC keeps the binary borrow.
  assign c_now   = (pass_q == 2'd0) ? alu_carry_out : (c_q | (dec_adc & alu_carry_out));
  // SBC fixes on borrow (no half-carry / no carry), ADC on carry.
  assign lo_fix  = (pass_q == 2'd0) &&
                   ((alu_dout[3:0] > 4'd9) || (dec_adc ? hc_vec[4] : !hc_vec[4]));
  assign hi_fix  = (alu_dout[7:4] > 4'd9) || (dec_adc ? c_now : !c_now);
`else
  logic unused_dec;
  assign unused_dec = &{1'b0, req_dec, dec_q};
  assign c_now      = (pass_q == 2'd0) ? alu_carry_out : c_q;
`endif

  assign v_vec  = ~(a_q ^ bs_q) & (a_q ^ r_q);
  assign flag_c = (op_q == OP_ASL || op_q == OP_ROL) ? a_q[DW-1] : c_q;

  always_comb begin
    case (op_q)
      OP_ADC, OP_SBC:         fmask = 4'b1111;
      OP_CMP, OP_ASL, OP_ROL: fmask = 4'b1011;
      default:                fmask = 4'b1010;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case can infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    bs_d        = bs_q;
    cin_d       = cin_q;
    dec_d       = dec_q;
    pass_d      = pass_q;
    r_d         = r_q;
    c_d         = c_q;
    err_d       = err_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    alu_cin_d   = alu_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_fmask_d = rsp_fmask_q;
    rsp_wb_d    = rsp_wb_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          a_d       = req_a;
          cin_d     = req_carry;
          dec_d     = req_dec;
          pass_d    = 2'd0;
          c_d       = 1'b0;
          err_d     = 1'b0;
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_cin_d = 1'b0;
          case (req_op)
            OP_ADC: begin alu_func_d = FN_SUM; alu_cin_d = req_carry; end
            OP_SBC: begin alu_func_d = FN_SUM; alu_b_d = ~req_b; alu_cin_d = req_carry; end
            OP_CMP: begin alu_func_d = FN_SUM; alu_b_d = ~req_b; alu_cin_d = 1'b1; end
            OP_AND: alu_func_d = FN_AND;
            OP_ORA: alu_func_d = FN_OR;
            OP_EOR: alu_func_d = FN_XOR;
            default: begin alu_func_d = FN_SR; alu_b_d = DW'(1); end
          endcase
          bs_d    = alu_b_d;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        r_d     = alu_dout;
        c_d     = c_now;
        state_d = S_DONE;
        if (!alu_wout) begin
          err_d = 1'b1;
        end else if (op_q == OP_ROL && pass_q == 2'd0) begin
          alu_a_d    = alu_dout;
          alu_b_d    = {{(DW-1){1'b0}}, cin_q};
          alu_func_d = FN_OR;
          alu_cin_d  = 1'b0;
          pass_d     = 2'd1;
          state_d    = S_ISSUE;
        end
`ifdef ALU_SEQ_DECIMAL_EN
        else if (dec_go && (lo_fix || hi_fix)) begin
          alu_a_d    = alu_dout;
          alu_func_d = FN_SUM;
          alu_cin_d  = 1'b0;
          state_d    = S_ISSUE;
          if (lo_fix) begin
            alu_b_d = dec_adc ? DW'(8'h06) : DW'(8'hFA);
            pass_d  = 2'd1;
          end else begin
            alu_b_d = dec_adc ? DW'(8'h60) : DW'(8'hA0);
            pass_d  = 2'd2;
          end
        end
`endif
      end

      default: begin
        // First DONE cycle publishes; outputs then hold until the consumer takes them.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = r_q;
          rsp_flags_d = {r_q[DW-1], v_vec[DW-1], (r_q == '0), flag_c} & fmask;
          rsp_fmask_d = fmask;
          rsp_wb_d    = (op_q != OP_CMP);
          rsp_err_d   = err_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          alu_func_d  = NOP_FUNC;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge phi1) begin
    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADC;
      a_q         <= '0;
      bs_q        <= '0;
      cin_q       <= 1'b0;
      dec_q       <= 1'b0;
      pass_q      <= 2'd0;
      r_q         <= '0;
      c_q         <= 1'b0;
      err_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= NOP_FUNC;
      alu_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0;
      rsp_fmask_q <= 4'b0;
      rsp_wb_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      bs_q        <= bs_d;
      cin_q       <= cin_d;
      dec_q       <= dec_d;
      pass_q      <= pass_d;
      r_q         <= r_d;
      c_q         <= c_d;
      err_q       <= err_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      alu_cin_q   <= alu_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_fmask_q <= rsp_fmask_d;
      rsp_wb_q    <= rsp_wb_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_func     = alu_func_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_fmask    = rsp_fmask_q;
  assign rsp_wb       = rsp_wb_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered ALU stub; set ALU_SEQ_DECIMAL_EN to cover BCD.
module tb_alu_op_sequencer;

  logic       phi1 = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_carry;
  logic       req_dec;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_func;
  logic       alu_carry_in;
  logic [7:0] alu_dout;
  logic       alu_wout;
  logic       alu_carry_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [3:0] rsp_fmask;
  logic       rsp_wb;
  logic       rsp_err;

  logic       bad_alu;
  int         checks = 0;
  int         errors = 0;
  int         edges;

  always #5 phi1 = ~phi1;

  alu_op_sequencer dut (
    .phi1(phi1), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_carry(req_carry), .req_dec(req_dec),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_carry_in(alu_carry_in),
    .alu_dout(alu_dout), .alu_wout(alu_wout), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_fmask(rsp_fmask), .rsp_wb(rsp_wb), .rsp_err(rsp_err)
  );

  // Registered ALU stub: 0 SUM, 1 AND, 2 OR, 3 XOR, 4 shift-left-by-b; anything else -> wout=0.
  logic [8:0] stub_sum;
  logic [8:0] stub_shl;
  assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_carry_in};
  assign stub_shl = {1'b0, alu_a} << alu_b[2:0];

  always_ff @(posedge phi1) begin
    case (alu_func)
      4'h0: begin {alu_carry_out, alu_dout} <= stub_sum; alu_wout <= !bad_alu; end
      4'h1: begin alu_dout <= alu_a & alu_b; alu_carry_out <= 1'b0; alu_wout <= !bad_alu; end
      4'h2: begin alu_dout <= alu_a | alu_b; alu_carry_out <= 1'b0; alu_wout <= !bad_alu; end
      4'h3: begin alu_dout <= alu_a ^ alu_b; alu_carry_out <= 1'b0; alu_wout <= !bad_alu; end
      4'h4: begin {alu_carry_out, alu_dout} <= stub_shl; alu_wout <= !bad_alu; end
      default: begin alu_dout <= 8'h00; alu_carry_out <= 1'b0; alu_wout <= 1'b0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  // Accept one request, then count edges until rsp_valid (bounded).
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d, output int n);
    req_op = op; req_a = a; req_b = b; req_carry = c; req_dec = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input int n, input int exp_n, input logic [7:0] data,
                           input logic [3:0] flags, input logic [3:0] fmask, input logic wb);
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_data"}, rsp_data, data);
    check({tag, "_flags"}, rsp_flags, flags);
    check({tag, "_fmask"}, rsp_fmask, fmask);
    check({tag, "_wb"}, rsp_wb, wb);
    check({tag, "_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; bad_alu = 1'b0;
    req_op = 3'd0; req_a = 8'h00; req_b = 8'h00; req_carry = 1'b0; req_dec = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_alu_func", alu_func, 4'hF);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_cin", alu_carry_in, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_flags", rsp_flags, 4'h0);
    reset = 1'b0;
    tick();

    // ADC 50+50: signed overflow into bit 7.
    req_op = 3'd0; req_a = 8'h50; req_b = 8'h50; req_carry = 1'b0; req_dec = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("adc_issue_func", alu_func, 4'h0);
    check("adc_issue_b", alu_b, 8'h50);
    check("adc_busy", req_ready, 1'b0);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 40) begin tick(); edges++; end
    check_rsp("adc", edges, 3, 8'hA0, 4'b1100, 4'hF, 1'b1);
    handshake();
    check("adc_drop_valid", rsp_valid, 1'b0);
    check("adc_idle_ready", req_ready, 1'b1);
    check("adc_idle_func", alu_func, 4'hF);

    run_op(3'd1, 8'h00, 8'h01, 1'b1, 1'b0, edges);
    check_rsp("sbc", edges, 3, 8'hFF, 4'b1000, 4'hF, 1'b1);
    handshake();

    run_op(3'd5, 8'h42, 8'h42, 1'b0, 1'b0, edges);
    check_rsp("cmp", edges, 3, 8'h00, 4'b0011, 4'hB, 1'b0);
    handshake();

    run_op(3'd7, 8'h81, 8'h00, 1'b1, 1'b0, edges);
    check_rsp("rol", edges, 5, 8'h03, 4'b0001, 4'hB, 1'b1);
    handshake();

    run_op(3'd6, 8'h81, 8'hFF, 1'b0, 1'b0, edges);
    check_rsp("asl", edges, 3, 8'h02, 4'b0001, 4'hB, 1'b1);
    handshake();

    run_op(3'd3, 8'h12, 8'h21, 1'b1, 1'b0, edges);
    check_rsp("ora", edges, 3, 8'h33, 4'b0000, 4'hA, 1'b1);
    handshake();

    // EOR then hold the response for 10 cycles while a new request waits.
    run_op(3'd4, 8'hF0, 8'h0F, 1'b0, 1'b0, edges);
    check_rsp("eor", edges, 3, 8'hFF, 4'b1000, 4'hA, 1'b1);
    req_op = 3'd2; req_a = 8'hF0; req_b = 8'h0F; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, 8'hFF);
      check("hold_flags", rsp_flags, 4'b1000);
      check("hold_ready", req_ready, 1'b0);
    end
    handshake();
    check("hold_release_ready", req_ready, 1'b1);
    run_op(3'd2, 8'hF0, 8'h0F, 1'b0, 1'b0, edges);
    check_rsp("and", edges, 3, 8'h00, 4'b0010, 4'hA, 1'b1);
    handshake();

    // Reset while ADC is in WAIT: response must never appear.
    req_op = 3'd0; req_a = 8'h11; req_b = 8'h22; req_carry = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", rsp_valid, 1'b0);
    check("abort_func", alu_func, 4'hF);
    check("abort_ready", req_ready, 1'b1);
    edges = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) edges++;
    end
    check("abort_no_rsp", edges, 0);

    // ALU reporting wout=0 flags an error.
    bad_alu = 1'b1;
    run_op(3'd0, 8'h01, 8'h01, 1'b0, 1'b0, edges);
    check("err_latency", edges, 3);
    check("err_flag", rsp_err, 1'b1);
    handshake();
    bad_alu = 1'b0;

`ifdef ALU_SEQ_DECIMAL_EN
    run_op(3'd0, 8'h09, 8'h01, 1'b0, 1'b1, edges);
    check_rsp("bcd_09_01", edges, 5, 8'h10, 4'b0000, 4'hF, 1'b1);
    handshake();
    run_op(3'd0, 8'h99, 8'h01, 1'b0, 1'b1, edges);
    check_rsp("bcd_99_01", edges, 7, 8'h00, 4'b0011, 4'hF, 1'b1);
    handshake();
`else
    run_op(3'd0, 8'h09, 8'h01, 1'b0, 1'b1, edges);
    check_rsp("dec_ignored", edges, 3, 8'h0A, 4'b0000, 4'hF, 1'b1);
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
